knight_sprite_sequencer: RTL and testbench
==========================================

// Module: knight_sprite_sequencer
// PURPOSE
//  Animation/address controller for the knight sprite ROMs (50x64 frames, 3-bit palette index).
//  Runs the knight anim FSM (idle/walk/jump/fall) once per video frame and picks the sheet and frame.
//  Per pixel, maps DrawX/DrawY into the knight box and emits a registered ROM address.
//  Emits a hit flag aligned with the ROM read (ROM clocked on ~vga_clk); sits between game logic and the ROM/palette muxes.
// PARAMETERS
//  SPR_W      50   sprite width (px)
//  SPR_H      64   sprite height (px)
//  WALK_FR    4    frames in walk sheet (idle/jump/fall sheets: 1 frame each)
//  FRAME_DIV  6    video frames per walk-animation step (>=1)
//  ADDR_W     14   ROM address width; must hold WALK_FR*SPR_W*SPR_H-1
// PORTS
//  vga_clk      in   1       pixel clock
//  reset        in   1       async, active-high
//  frame_start  in   1       1-cycle pulse at start of vblank
//  DrawX,DrawY  in   10 ea   current pixel
//  knight_x     in   10      box top-left X
//  knight_y     in   10      box top-left Y
//  move_left    in   1       level, from game logic
//  move_right   in   1       level
//  jump_req     in   1       level; sampled at frame_start
//  on_ground    in   1       level; sampled at frame_start
//  rom_address  out  ADDR_W  registered address into the selected sheet
//  sheet_sel    out  2       0 idle, 1 walk, 2 jump, 3 fall
//  sprite_hit   out  1       pixel inside box, aligned with rom_q
//  facing_left  out  1       last horizontal direction
// BEHAVIOUR
//  Reset: state IDLE, rom_address 0, sheet_sel 0, sprite_hit 0, facing_left 0, frame_idx 0, div_cnt 0.
//  FSM updates only on frame_start; between pulses all anim state is held.
//   IDLE -> JUMP_RISE if jump_req&on_ground; else -> WALK if move_left^move_right.
//   WALK -> JUMP_RISE if jump_req&on_ground; -> FALL if !on_ground; -> IDLE if !(move_left^move_right).
//   JUMP_RISE -> FALL after 1 frame_start (rise timing owned by physics); FALL -> IDLE when on_ground.
//   Priority per pulse: jump > fall > walk > idle.
//  Facing: on frame_start, left&!right -> 1, right&!left -> 0, both/none -> hold.
//  Walk counter: in WALK, div_cnt++ per frame_start; at FRAME_DIV-1, div_cnt->0 and
//   frame_idx = (frame_idx==WALK_FR-1) ? 0 : frame_idx+1. Entering WALK clears both; other states hold frame_idx 0.
//  Pixel path (every vga_clk): dx=DrawX-knight_x, dy=DrawY-knight_y as 11-bit signed.
//   in_box = 0<=dx<SPR_W && 0<=dy<SPR_H (box clipping at X>=640 is legal, just no hits).
//   rom_address <= frame_idx*SPR_W*SPR_H + dy*SPR_W + col; 0 when !in_box. sprite_hit <= in_box.
//   ROM registers on the following negedge, so rom_q and sprite_hit are valid together one vga_clk after DrawX.
//  frame_start coinciding with an in-box pixel: address uses pre-update frame_idx (update is in vblank anyway).
//  Async reset mid-line: outputs drop to reset values immediately; operation resumes at the next edge.
// CONFIGURATION
//  KNIGHT_MIRROR_EN defined: col = facing_left ? SPR_W-1-dx : dx (horizontal flip).
//  Not defined: col = dx always; facing_left is still generated.
// STRUCTURE
//  knight_sprite_pkg: anim_state_t enum {IDLE,WALK,JUMP_RISE,FALL}, sheet codes, SPR_W/SPR_H localparams.
//  Sub-module knight_anim_fsm: state, facing, div_cnt, frame_idx (frame_start domain).
//  The top level holds the pixel address/hit pipeline only.
// TESTING
//  Reset: assert mid-line -> all outputs 0 the same cycle; after release, IDLE, sheet_sel=0.
//  knight_x=100,y=200; DrawX=100,DrawY=200 -> next cycle rom_address=0, hit=1; DrawX=149,DrawY=263 -> 3199.
//  DrawX=99 or 150 or DrawY=264 -> hit=0, rom_address=0.
//  move_right held, FRAME_DIV=6: frame_idx steps 0,1,2,3,0 every 6 pulses; address at (0,0) steps 0,3200,6400,9600,0.
//  jump_req&on_ground at pulse -> sheet 2; next pulse -> 3; on_ground=1 -> 0; jump_req while !on_ground ignored.
//  KNIGHT_MIRROR_EN, facing_left=1, dx=0,dy=0 -> address 49; without macro -> 0; both dirs held -> facing unchanged.

Source files
------------

// File: rtl/knight_sprite_pkg.sv
// Shared types and constants for the knight sprite sequencer:
// animation state enum, sheet select codes and sprite geometry.
package knight_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WALK      = 2'd1,
        JUMP_RISE = 2'd2,
        FALL      = 2'd3
    } anim_state_t;

    localparam logic [1:0] SHEET_IDLE = 2'd0;
    localparam logic [1:0] SHEET_WALK = 2'd1;
    localparam logic [1:0] SHEET_JUMP = 2'd2;
    localparam logic [1:0] SHEET_FALL = 2'd3;

    localparam int SPR_W = 50;
    localparam int SPR_H = 64;

    // Map an animation state onto the ROM sheet that holds its frames.
    function automatic logic [1:0] sheet_of(input anim_state_t st);
        logic [1:0] sh;
        case (st)
            IDLE:      sh = SHEET_IDLE;
            WALK:      sh = SHEET_WALK;
            JUMP_RISE: sh = SHEET_JUMP;
            FALL:      sh = SHEET_FALL;
            default:   sh = SHEET_IDLE;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/knight_anim_fsm.sv
// Knight animation controller: idle/walk/jump/fall state, facing direction,
// and the walk-cycle frame divider. All state advances only on frame_start,
// so the pixel path always sees stable frame_idx/facing during active video.
module knight_anim_fsm
    import knight_sprite_pkg::*;
#(
    parameter int WALK_FR   = 4,
    parameter int FRAME_DIV = 6,
    localparam int FI_W     = (WALK_FR > 1) ? $clog2(WALK_FR) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            move_left,
    input  logic            move_right,
    input  logic            jump_req,
    input  logic            on_ground,
    output logic [FI_W-1:0] frame_idx,
    output logic [1:0]      sheet_sel,
    output logic            facing_left
);

    localparam int DC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DC_W-1:0] DIV_LAST = DC_W'(FRAME_DIV - 1);
    localparam logic [FI_W-1:0] FI_LAST  = FI_W'(WALK_FR - 1);

    anim_state_t     state_q, state_d;
    logic            facing_q, facing_d;
    logic [DC_W-1:0] div_cnt_q, div_cnt_d;
    logic [FI_W-1:0] frame_idx_q, frame_idx_d;
    logic            horiz_s;

    // Next-state, facing and walk-frame logic, evaluated only on frame_start.
    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        div_cnt_d   = div_cnt_q;
        frame_idx_d = frame_idx_q;
        horiz_s     = move_left ^ move_right;
        if (frame_start) begin
            case (state_q)
                IDLE: begin
                    if (jump_req && on_ground) state_d = JUMP_RISE;
                    else if (horiz_s)          state_d = WALK;
                    else                       state_d = IDLE;
                end
                WALK: begin
                    if (jump_req && on_ground) state_d = JUMP_RISE;
                    else if (!on_ground)       state_d = FALL;
                    else if (!horiz_s)         state_d = IDLE;
                    else                       state_d = WALK;
                end
                // Rise duration belongs to the physics block; we only show one rise frame.
                JUMP_RISE: state_d = FALL;
                FALL: begin
                    if (on_ground) state_d = IDLE;
                    else           state_d = FALL;
                end
                default: state_d = IDLE;
            endcase

            if (move_left && !move_right)      facing_d = 1'b1;
            else if (move_right && !move_left) facing_d = 1'b0;
            else                               facing_d = facing_q;

            // Walk cycle only advances while staying in WALK; entering or leaving clears it.
            if ((state_q == WALK) && (state_d == WALK)) begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d   = '0;
                    frame_idx_d = (frame_idx_q == FI_LAST) ? '0 : frame_idx_q + FI_W'(1);
                end else begin
                    div_cnt_d   = div_cnt_q + DC_W'(1);
                    frame_idx_d = frame_idx_q;
                end
            end else begin
                div_cnt_d   = '0;
                frame_idx_d = '0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Animation state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            facing_q    <= 1'b0;
            div_cnt_q   <= '0;
            frame_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            div_cnt_q   <= div_cnt_d;
            frame_idx_q <= frame_idx_d;
        end
    end

    assign frame_idx   = frame_idx_q;
    assign sheet_sel   = sheet_of(state_q);
    assign facing_left = facing_q;

endmodule

// File: rtl/knight_sprite_sequencer.sv
// Knight sprite sequencer top: per-pixel ROM address and hit pipeline,
// driven by the animation controller in knight_anim_fsm.
// Optional build macro KNIGHT_MIRROR_EN: flips the sprite horizontally when
// facing left. Without it the column is used unflipped.
module knight_sprite_sequencer #(
    parameter int SPR_W     = knight_sprite_pkg::SPR_W,
    parameter int SPR_H     = knight_sprite_pkg::SPR_H,
    parameter int WALK_FR   = 4,
    parameter int FRAME_DIV = 6,
    parameter int ADDR_W    = 14
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        knight_x,
    input  logic [9:0]        knight_y,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              jump_req,
    input  logic              on_ground,
    output logic [ADDR_W-1:0] rom_address,
    output logic [1:0]        sheet_sel,
    output logic              sprite_hit,
    output logic              facing_left
);

    localparam int FI_W = (WALK_FR > 1) ? $clog2(WALK_FR) : 1;

    logic [FI_W-1:0]   frame_idx_s;
    logic              facing_left_s;
    logic signed [10:0] dx_s, dy_s;
    logic [9:0]        col_s;
    logic              in_box_d;
    logic [ADDR_W-1:0] rom_address_d, rom_address_q;
    logic              sprite_hit_q;

    knight_anim_fsm #(
        .WALK_FR   (WALK_FR),
        .FRAME_DIV (FRAME_DIV)
    ) u_anim (
        .clk         (vga_clk),
        .rst         (reset),
        .frame_start (frame_start),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump_req    (jump_req),
        .on_ground   (on_ground),
        .frame_idx   (frame_idx_s),
        .sheet_sel   (sheet_sel),
        .facing_left (facing_left_s)
    );

    // Box-relative coordinates, box test and ROM address for the current pixel.
    always_comb begin
        dx_s     = $signed({1'b0, DrawX}) - $signed({1'b0, knight_x});
        dy_s     = $signed({1'b0, DrawY}) - $signed({1'b0, knight_y});
        in_box_d = !dx_s[10] && (dx_s[9:0] < 10'(SPR_W)) &&
                   !dy_s[10] && (dy_s[9:0] < 10'(SPR_H));
`ifdef KNIGHT_MIRROR_EN
        if (facing_left_s) col_s = 10'(SPR_W - 1) - dx_s[9:0];
        else               col_s = dx_s[9:0];
`else
        col_s = dx_s[9:0];
`endif
        if (in_box_d) begin
            rom_address_d = ADDR_W'(frame_idx_s) * ADDR_W'(SPR_W * SPR_H)
                          + ADDR_W'(dy_s[9:0]) * ADDR_W'(SPR_W)
                          + ADDR_W'(col_s);
        end else begin
            rom_address_d = '0;
        end
    end

    // Output registers; the ROM samples rom_address on the following negedge,
    // so sprite_hit lines up with rom_q one pixel clock after DrawX.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address_q <= '0;
            sprite_hit_q  <= 1'b0;
        end else begin
            rom_address_q <= rom_address_d;
            sprite_hit_q  <= in_box_d;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_hit  = sprite_hit_q;
    assign facing_left = facing_left_s;

endmodule

// File: tb/tb_knight_sprite_sequencer.sv
// Self-checking bench for knight_sprite_sequencer with a behavioural model.
module tb_knight_sprite_sequencer;

    localparam int FRAME_DIV = 6;
    localparam int WALK_FR   = 4;

    logic        vga_clk = 1'b0;
    logic        reset, frame_start;
    logic [9:0]  DrawX, DrawY, knight_x, knight_y;
    logic        move_left, move_right, jump_req, on_ground;
    logic [13:0] rom_address;
    logic [1:0]  sheet_sel;
    logic        sprite_hit, facing_left;

    int passed = 0;
    int total  = 0;

    // model: 0 idle, 1 walk, 2 jump, 3 fall
    int m_state, m_face, m_walk;

    knight_sprite_sequencer dut (
        .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .knight_x(knight_x), .knight_y(knight_y),
        .move_left(move_left), .move_right(move_right), .jump_req(jump_req),
        .on_ground(on_ground), .rom_address(rom_address), .sheet_sel(sheet_sel),
        .sprite_hit(sprite_hit), .facing_left(facing_left)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_state = 0; m_face = 0; m_walk = 0;
    endfunction

    function automatic void model_pulse();
        int ns;
        bit horiz;
        horiz = move_left ^ move_right;
        case (m_state)
            0: ns = (jump_req && on_ground) ? 2 : (horiz ? 1 : 0);
            1: ns = (jump_req && on_ground) ? 2 : (!on_ground ? 3 : (horiz ? 1 : 0));
            2: ns = 3;
            default: ns = on_ground ? 0 : 3;
        endcase
        if (ns == 1) m_walk = (m_state == 1) ? m_walk + 1 : 0;
        else         m_walk = 0;
        m_state = ns;
        if (move_left && !move_right) m_face = 1;
        else if (move_right && !move_left) m_face = 0;
    endfunction

    function automatic int model_addr(output int hit);
        int dx, dy, col, fr;
        dx = int'(DrawX) - int'(knight_x);
        dy = int'(DrawY) - int'(knight_y);
        hit = (dx >= 0 && dx < 50 && dy >= 0 && dy < 64) ? 1 : 0;
        fr  = (m_walk / FRAME_DIV) % WALK_FR;
`ifdef KNIGHT_MIRROR_EN
        col = (m_face == 1) ? 49 - dx : dx;
`else
        col = dx;
`endif
        return hit ? fr * 3200 + dy * 50 + col : 0;
    endfunction

    // One clock with full-output comparison against the model.
    task automatic tick(input string tag);
        int ea, eh;
        ea = model_addr(eh);
        @(posedge vga_clk);
        #1;
        if (frame_start) model_pulse();
        chk({tag, "_addr"},  32'(rom_address), 32'(ea));
        chk({tag, "_hit"},   32'(sprite_hit),  32'(eh));
        chk({tag, "_sheet"}, 32'(sheet_sel),   32'(m_state));
        chk({tag, "_face"},  32'(facing_left), 32'(m_face));
    endtask

    task automatic pulse(input string tag);
        frame_start = 1'b1;
        tick(tag);
        frame_start = 1'b0;
    endtask

    initial begin
        int px [6];
        int py [6];
        int walk_exp [5];
        logic [9:0] r;
        px = '{100, 149, 99, 150, 100, 100};
        py = '{200, 263, 200, 200, 264, 199};
        walk_exp = '{0, 3200, 6400, 9600, 0};

        reset = 1'b1; frame_start = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; knight_x = 10'd0; knight_y = 10'd0;
        move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0; on_ground = 1'b1;
        model_reset();

        #2;
        chk("rst_addr",  32'(rom_address), 32'd0);
        chk("rst_hit",   32'(sprite_hit),  32'd0);
        chk("rst_sheet", 32'(sheet_sel),   32'd0);
        chk("rst_face",  32'(facing_left), 32'd0);
        @(posedge vga_clk); #1;
        reset = 1'b0;

        // Box edges at knight (100,200).
        knight_x = 10'd100; knight_y = 10'd200;
        for (int i = 0; i < 6; i++) begin
            DrawX = 10'(px[i]); DrawY = 10'(py[i]);
            tick("box");
            if (i == 0) chk("box_origin", 32'(rom_address), 32'd0);
            if (i == 1) chk("box_corner", 32'(rom_address), 32'd3199);
            if (i >= 2) chk("box_out_hit", 32'(sprite_hit), 32'd0);
        end

        // Walk cycle with move_right held.
        DrawX = 10'd100; DrawY = 10'd200; move_right = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            pulse("walk_p");
            tick("walk_a");
            if (n % 6 == 1) chk("walk_step", 32'(rom_address), 32'(walk_exp[(n - 1) / 6]));
        end

        // Jump sequence.
        move_right = 1'b0; jump_req = 1'b1; on_ground = 1'b1;
        pulse("jump1");
        chk("jump_sheet", 32'(sheet_sel), 32'd2);
        on_ground = 1'b0;
        pulse("jump2");
        chk("fall_sheet", 32'(sheet_sel), 32'd3);
        pulse("jump3");
        chk("air_jump_ignored", 32'(sheet_sel), 32'd3);
        on_ground = 1'b1; jump_req = 1'b0;
        pulse("land");
        chk("land_sheet", 32'(sheet_sel), 32'd0);

        // Facing left and mirroring.
        move_left = 1'b1;
        pulse("face_l");
        tick("mirror");
`ifdef KNIGHT_MIRROR_EN
        chk("mirror_addr", 32'(rom_address), 32'd49);
`else
        chk("mirror_addr", 32'(rom_address), 32'd0);
`endif
        move_right = 1'b1;
        pulse("both_dirs");
        chk("both_hold_face", 32'(facing_left), 32'd1);

        // Async reset in the middle of a line while walking.
        move_right = 1'b0;
        pulse("pre_rst");
        tick("pre_rst2");
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_addr",  32'(rom_address), 32'd0);
        chk("mid_rst_hit",   32'(sprite_hit),  32'd0);
        chk("mid_rst_sheet", 32'(sheet_sel),   32'd0);
        chk("mid_rst_face",  32'(facing_left), 32'd0);
        model_reset();
        move_left = 1'b0;
        @(posedge vga_clk); #1;
        reset = 1'b0;
        tick("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                knight_x = 10'($urandom_range(0, 1023));
                knight_y = 10'($urandom_range(0, 1023));
            end
            r = 10'($urandom_range(0, 60));
            DrawX = knight_x + r - 10'd5;
            r = 10'($urandom_range(0, 74));
            DrawY = knight_y + r - 10'd5;
            move_left   = 1'($urandom_range(0, 1));
            move_right  = 1'($urandom_range(0, 1));
            jump_req    = ($urandom_range(0, 7) == 0);
            on_ground   = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 9) == 0);
            tick("rand");
        end
        frame_start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
